// File: rtl/game_pkg.sv
// Shared game definitions: difficulty encodings, per-difficulty mole timing,
// and the mole controller state encoding.
package game_pkg;

  localparam int unsigned POS_W  = 3;
  localparam int unsigned MS_W   = 10;
  localparam int unsigned LFSR_W = 16;

  typedef enum logic [1:0] {
    DIFF_EASY = 2'd0,
    DIFF_MED  = 2'd1,
    DIFF_HARD = 2'd2
  } diff_e;

  typedef enum logic [1:0] {
    MOLE_IDLE = 2'd0,
    MOLE_GAP  = 2'd1,
    MOLE_UP   = 2'd2
  } mole_state_e;

  // Level 3 is not a distinct difficulty; it plays as hard.
  function automatic diff_e norm_diff(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return DIFF_EASY;
      2'd1:    return DIFF_MED;
      default: return DIFF_HARD;
    endcase
  endfunction

  function automatic logic [MS_W-1:0] up_ms(input diff_e d);
    case (d)
      DIFF_EASY: return MS_W'(1000);
      DIFF_MED:  return MS_W'(700);
      default:   return MS_W'(450);
    endcase
  endfunction

  function automatic logic [MS_W-1:0] gap_ms(input diff_e d);
    case (d)
      DIFF_EASY: return MS_W'(300);
      DIFF_MED:  return MS_W'(200);
      default:   return MS_W'(150);
    endcase
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying a 3-bit
// pseudo-random hole position.
module mole_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] pos_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pos_o = lfsr_q[POS_W-1:0];

endmodule

// File: rtl/mole_ctrl.sv
// Whack-a-mole controller: pops one mole at a time with per-difficulty up/gap
// timing and reports hit/miss pulses for scoring.
module mole_ctrl
  import game_pkg::*;
#(
  parameter int unsigned       NUM_MOLES    = 8,
  parameter int unsigned       TICKS_PER_MS = 100000,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           difficulty_level,
  input  logic [NUM_MOLES-1:0] whack,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int unsigned PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  mole_state_e            state_q, state_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [MS_W-1:0]        ms_cnt_q, ms_cnt_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [POS_W-1:0]       prev_pos_q, prev_pos_d;
  diff_e                  diff_q, diff_d;
  logic [NUM_MOLES-1:0]   leds_q, leds_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;

  logic [POS_W-1:0]       lfsr_pos_c;
  logic [POS_W-1:0]       new_pos_c;
  logic                   ms_tick_c;
  logic                   whack_hit_c;
  logic                   whack_wrong_c;
  logic [MS_W-1:0]        up_lim_c;
  logic [MS_W-1:0]        gap_lim_c;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .pos_o (lfsr_pos_c)
  );

  // Never repeat the previous hole: bump a collision to the next hole.
  assign new_pos_c     = (lfsr_pos_c == prev_pos_q) ? lfsr_pos_c + 1'b1 : lfsr_pos_c;
  assign ms_tick_c     = (presc_q == PRESC_W'(TICKS_PER_MS - 1));
  assign whack_hit_c   = whack[pos_q];
  assign whack_wrong_c = |(whack & ~(NUM_MOLES'(1) << pos_q));
  assign up_lim_c      = up_ms(diff_q);
  assign gap_lim_c     = gap_ms(diff_q);

  always_comb begin
    presc_d = ms_tick_c ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    prev_pos_d = prev_pos_q;
    diff_d     = diff_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    ms_cnt_d   = ms_cnt_q;
    leds_d     = '0;

    if (!enable) begin
      state_d = MOLE_IDLE;
    end else begin
      unique case (state_q)
        MOLE_IDLE: state_d = MOLE_GAP;
        MOLE_GAP: begin
          if (ms_cnt_q == gap_lim_c) begin
            state_d    = MOLE_UP;
            pos_d      = new_pos_c;
            prev_pos_d = new_pos_c;
            diff_d     = norm_diff(difficulty_level);
          end
        end
        MOLE_UP: begin
          // A correct whack wins over both a wrong bit and a timeout.
          if (whack_hit_c) begin
            hit_d   = 1'b1;
            state_d = MOLE_GAP;
          end else if (ms_cnt_q == up_lim_c) begin
            miss_d  = 1'b1;
            state_d = MOLE_GAP;
          end else if (whack_wrong_c) begin
            miss_d  = 1'b1;
          end
        end
        default: state_d = MOLE_IDLE;
      endcase
    end

    if (!enable || (state_d != state_q)) begin
      ms_cnt_d = '0;
    end else if (ms_tick_c) begin
      ms_cnt_d = ms_cnt_q + 1'b1;
    end

    if (state_d == MOLE_UP) begin
      leds_d = NUM_MOLES'(1) << pos_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MOLE_IDLE;
      presc_q    <= '0;
      ms_cnt_q   <= '0;
      pos_q      <= '0;
      prev_pos_q <= '0;
      diff_q     <= DIFF_EASY;
      leds_q     <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_cnt_q   <= ms_cnt_d;
      pos_q      <= pos_d;
      prev_pos_q <= prev_pos_d;
      diff_q     <= diff_d;
      leds_q     <= leds_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign mole_leds  = leds_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_ctrl.sv
// Self-checking bench for mole_ctrl: cycle-exact timing and position model
// derived from the millisecond/LFSR rules, with randomized whack stimulus.
module tb_mole_ctrl;

  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] difficulty_level;
  logic [7:0] whack;
  logic [7:0] mole_leds;
  logic       hit_pulse;
  logic       miss_pulse;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [15:0] lfsr_m, lfsr_prev;
  int          cyc_m;
  int          diff_lat   = 0;
  logic [2:0]  prev_pos_m = 3'd0;
  int          gap_entry  = 0;

  always #5 clk = ~clk;

  mole_ctrl #(
    .NUM_MOLES    (8),
    .TICKS_PER_MS (T),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .difficulty_level (difficulty_level),
    .whack            (whack),
    .mole_leds        (mole_leds),
    .hit_pulse        (hit_pulse),
    .miss_pulse       (miss_pulse)
  );

  // Reference: LFSR sequence and cycles elapsed since reset (ms prescaler phase).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
      cyc_m     <= 0;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      cyc_m     <= cyc_m + 1;
    end
  end

  function automatic int up_ms(input int d);
    if (d == 0) return 1000;
    if (d == 1) return 700;
    return 450;
  endfunction

  function automatic int gap_ms(input int d);
    if (d == 0) return 300;
    if (d == 1) return 200;
    return 150;
  endfunction

  // First sample of the next state after a timed state entered at sample 'entry'
  // that lasts until n millisecond ticks have been counted.
  function automatic int exit_cyc(input int entry, input int n);
    return entry + (T - 1 - (entry % T)) + (n - 1) * T + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mole_model(output logic [2:0] p);
    logic [2:0] l;
    l = lfsr_prev[2:0];
    p = (l == prev_pos_m) ? l + 3'd1 : l;
    prev_pos_m = p;
    diff_lat = (difficulty_level > 2'd2) ? 2 : int'(difficulty_level);
  endtask

  task automatic wait_mole(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (mole_leds != 8'h00) begin
        at = cyc_m;
        return;
      end
      tick();
    end
  endtask

  task automatic arrive(input string name, output logic [2:0] p);
    int at, exp_at;
    logic [7:0] exp_leds;
    exp_at = exit_cyc(gap_entry, gap_ms(diff_lat));
    wait_mole(4000, at);
    vectors++;
    if (at !== exp_at) begin
      miscompares++;
      $display("FAIL %s_arrival: got cycle %0d expected %0d", name, at, exp_at);
    end
    mole_model(p);
    exp_leds = 8'h01 << p;
    vectors++;
    if (mole_leds !== exp_leds) begin
      miscompares++;
      $display("FAIL %s_pos: got leds %02h expected %02h", name, mole_leds, exp_leds);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; difficulty_level = 2'd0; whack = 8'h00;
    repeat (3) tick();
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %03h expected 000", {mole_leds, hit_pulse, miss_pulse});
    end
    rst_n = 1'b1;
    repeat (20) tick();
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'd0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %03h expected 000", {mole_leds, hit_pulse, miss_pulse});
    end
  endtask

  task automatic test_timeout();
    logic [2:0] p;
    logic [7:0] lit;
    int n, exp_end;
    bit quiet, steady;
    enable = 1'b1;
    tick();
    gap_entry = cyc_m;
    arrive("easy_first", p);
    lit = 8'h01 << p;
    exp_end = exit_cyc(cyc_m, up_ms(diff_lat));
    n = 0; quiet = 1'b1; steady = 1'b1;
    while (mole_leds != 8'h00 && n < 12000) begin
      if (hit_pulse || miss_pulse) quiet = 1'b0;
      if (mole_leds !== lit) steady = 1'b0;
      tick();
      n++;
    end
    vectors++;
    if (!quiet || !steady) begin
      miscompares++;
      $display("FAIL easy_up_quiet: got quiet=%0b steady=%0b expected 1 1", quiet, steady);
    end
    vectors++;
    if (cyc_m !== exp_end) begin
      miscompares++;
      $display("FAIL easy_up_length: led off at cycle %0d expected %0d", cyc_m, exp_end);
    end
    vectors++;
    if ({hit_pulse, miss_pulse} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_pulse: got hit,miss=%b expected 01", {hit_pulse, miss_pulse});
    end
    gap_entry = cyc_m;
    tick();
    vectors++;
    if (miss_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse_width: got miss=%b expected 0", miss_pulse);
    end
  endtask

  task automatic test_hit();
    logic [2:0] p;
    difficulty_level = 2'd2;
    arrive("hard_first", p);
    repeat (1000) tick();
    whack = 8'h01 << p;
    tick();
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'b0000000010) begin
      miscompares++;
      $display("FAIL hit_response: got leds=%02h hit,miss=%b expected 00 10", mole_leds, {hit_pulse, miss_pulse});
    end
    gap_entry = cyc_m;
    tick();
    vectors++;
    if (hit_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_pulse_width: got %b expected 0", hit_pulse);
    end
    arrive("hard_gap", p);
  endtask

  task automatic test_wrong();
    logic [2:0] p;
    logic [7:0] lit, wrong;
    p = prev_pos_m;
    lit = 8'h01 << p;
    wrong = 8'h01 << (p + 3'd5);
    whack = wrong;
    tick();
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== {lit, 2'b01}) begin
      miscompares++;
      $display("FAIL wrong_single: got leds=%02h hit,miss=%b expected %02h 01", mole_leds, {hit_pulse, miss_pulse}, lit);
    end
    whack = ~lit;
    tick();
    whack = 8'h00;
    vectors++;
    if ({hit_pulse, miss_pulse} !== 2'b01) begin
      miscompares++;
      $display("FAIL wrong_multi: got hit,miss=%b expected 01", {hit_pulse, miss_pulse});
    end
    tick();
    vectors++;
    if (miss_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wrong_multi_once: got miss=%b expected 0", miss_pulse);
    end
    whack = wrong;
    tick();
    vectors++;
    if (miss_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL wrong_consec_1: got miss=%b expected 1", miss_pulse);
    end
    tick();
    whack = 8'h00;
    vectors++;
    if (miss_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL wrong_consec_2: got miss=%b expected 1", miss_pulse);
    end
    whack = wrong | lit;
    tick();
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'b0000000010) begin
      miscompares++;
      $display("FAIL hit_with_wrong: got leds=%02h hit,miss=%b expected 00 10", mole_leds, {hit_pulse, miss_pulse});
    end
    gap_entry = cyc_m;
  endtask

  task automatic test_timeout_hit();
    logic [2:0] p;
    logic [7:0] lit;
    int tcyc, n;
    arrive("edge", p);
    lit = 8'h01 << p;
    tcyc = exit_cyc(cyc_m, up_ms(diff_lat)) - 1;
    n = 0;
    while (cyc_m < tcyc && n < 6000) begin
      tick();
      n++;
    end
    vectors++;
    if (mole_leds !== lit) begin
      miscompares++;
      $display("FAIL timeout_cycle_lit: got leds=%02h expected %02h at cycle %0d", mole_leds, lit, cyc_m);
    end
    whack = lit;
    tick();
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'b0000000010) begin
      miscompares++;
      $display("FAIL timeout_hit: got leds=%02h hit,miss=%b expected 00 10", mole_leds, {hit_pulse, miss_pulse});
    end
    gap_entry = cyc_m;
    tick();
    vectors++;
    if ({hit_pulse, miss_pulse} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_hit_after: got hit,miss=%b expected 00", {hit_pulse, miss_pulse});
    end
  endtask

  task automatic test_random();
    logic [2:0] p, last;
    logic [7:0] lit, m;
    int act;
    bit quiet;
    last = prev_pos_m;
    for (int k = 0; k < 16; k++) begin
      arrive("rand", p);
      lit = 8'h01 << p;
      act = -1;
      for (int b = 0; b < 8; b++) if (mole_leds[b]) act = b;
      vectors++;
      if (!$onehot(mole_leds) || act == int'(last)) begin
        miscompares++;
        $display("FAIL rand_no_repeat: got leds=%02h previous pos %0d", mole_leds, last);
      end
      last = p;
      difficulty_level = 2'($urandom_range(1, 3));
      quiet = 1'b1;
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        repeat ($urandom_range(0, 20)) begin
          tick();
          if (hit_pulse || miss_pulse || mole_leds !== lit) quiet = 1'b0;
        end
        m = 8'($urandom) & ~lit;
        whack = (m == 8'h00) ? (8'h01 << (p + 3'd1)) : m;
        tick();
        whack = 8'h00;
        vectors++;
        if ({mole_leds, hit_pulse, miss_pulse} !== {lit, 2'b01}) begin
          miscompares++;
          $display("FAIL rand_wrong: got leds=%02h hit,miss=%b expected %02h 01", mole_leds, {hit_pulse, miss_pulse}, lit);
        end
      end
      repeat ($urandom_range(1, 50)) begin
        tick();
        if (hit_pulse || miss_pulse || mole_leds !== lit) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
        miscompares++;
        $display("FAIL rand_quiet: spurious pulse or LED change while waiting, leds=%02h", mole_leds);
      end
      whack = lit | 8'($urandom);
      tick();
      whack = 8'h00;
      vectors++;
      if ({mole_leds, hit_pulse, miss_pulse} !== 10'b0000000010) begin
        miscompares++;
        $display("FAIL rand_hit: got leds=%02h hit,miss=%b expected 00 10", mole_leds, {hit_pulse, miss_pulse});
      end
      gap_entry = cyc_m;
    end
  endtask

  task automatic test_enable_drop();
    logic [2:0] p;
    bit quiet;
    arrive("drop", p);
    repeat (3) tick();
    enable = 1'b0;
    whack = 8'h01 << p;
    tick();
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'd0) begin
      miscompares++;
      $display("FAIL drop_enable: got leds=%02h hit,miss=%b expected 00 00", mole_leds, {hit_pulse, miss_pulse});
    end
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if ({mole_leds, hit_pulse, miss_pulse} !== 10'd0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL drop_idle: outputs active while disabled, leds=%02h", mole_leds);
    end
    enable = 1'b1;
    tick();
    gap_entry = cyc_m;
    arrive("reenable", p);
  endtask

  task automatic test_async_reset();
    whack = 8'h01 << prev_pos_m;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    whack = 8'h00;
    vectors++;
    if ({mole_leds, hit_pulse, miss_pulse} !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset: got leds=%02h hit,miss=%b expected 00 00", mole_leds, {hit_pulse, miss_pulse});
    end
    tick();
    rst_n = 1'b1;
    prev_pos_m = 3'd0;
    diff_lat = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_wrong();
    test_timeout_hit();
    test_random();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
